bcd_counter_sseg: RTL and testbench
===================================

# bcd_counter_sseg

Parametrised N-digit BCD up/down counter with load, wrap detection and a built-in time-multiplexed seven-segment scanner with leading-zero blanking. Carry and borrow are true decimal across all digits. The block drives the board's anode and segment pins directly, so a top level needs no separate display mux. Typical use is the switch-driven BCD increment demos and any decimal counter shown on the display.

## Interface
- DIGITS, 4: number of BCD digits counted and scanned (1..8).
- DIV_BITS, 16: scan prescaler width; each digit is shown for 2^DIV_BITS cycles.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show every digit.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load load_val into the counter.
- load_val  in  4*DIGITS  BCD value to load; digit 0 is at [3:0].
- inc  in  1  increment by 1 (decimal).
- dec  in  1  decrement by 1 (decimal).
- cnt  out  4*DIGITS  current BCD count, registered.
- wrap  out  1  one-cycle pulse when a count wraps (9..9→0 or 0→9..9).
- err  out  1  one-cycle pulse when a load is rejected for an invalid nibble.
- an  out  DIGITS  active-low digit enables, registered.
- seg  out  8  active-low segments: {dp,g,f,e,d,c,b,a}, registered; dp is always 1 (off).

## Operation
- The counter updates once per clock. Priority is: load, then (inc & dec: hold), then inc, then dec, then hold.
- Load with every nibble of load_val ≤ 9: cnt ← load_val, no wrap.
- Load with any nibble > 9: cnt is unchanged and err pulses. inc/dec are ignored in that cycle.
- Increment:
  - Digit 0 +1. A digit at 9 becomes 0 and carries to the next digit.
  - All digits at 9 → all 0, and wrap pulses.
- Decrement:
  - Digit 0 −1. A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 → all 9, and wrap pulses.
- cnt never holds a nibble > 9.
- Scanner:
  - The prescaler counts up from 0. When it reaches all ones, digit index idx advances as 0,1,…,DIGITS−1,0.
  - Every cycle, an ← ~(1<<idx) and seg ← encode(cnt digit idx).
- Encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking: when BLANK_LZ=1, digit i>0 is blank when digits i..DIGITS−1 are all 0. Digit 0 is never blank, so a zero count shows a single "0".

## Timing
- Reset values: cnt=0, wrap=0, err=0, an=all 1, seg=8'hFF, prescaler=0, idx=0.
- load/inc/dec sampled at edge k appear on cnt after edge k. wrap and err are high for exactly that one following cycle.
- an/seg reflect cnt as it was before edge k, so the display lags cnt by one cycle.
- First display drive is at the first edge with reset low: an=~1 (digit 0 on).
- idx first advances after 2^DIV_BITS clock edges with reset low. Each digit then holds for exactly 2^DIV_BITS cycles.
- Reset asserted mid-operation clears everything at the next edge and overrides load/inc/dec in the same cycle.
- A count change mid-slot updates the displayed digit one cycle later. The scan phase is unaffected.
- Exactly one an bit is low at any time after reset.

## Test plan
All scenarios use DIGITS=4, DIV_BITS=2.

- Reset, then idle 20 cycles → cnt=0000; an sequences 1110,1101,1011,0111 with 4 cycles each; seg=1100_0000 ("0") on digit 0 and 1111_1111 on digits 1-3.
- load 0x0199, then one inc → cnt=0x0200 with no wrap; scan shows digits 3 blank, 2="2", 1="0", 0="0".
- load 0x9999, then inc → cnt=0x0000 and wrap high for exactly 1 cycle. Then dec → cnt=0x9999 and wrap pulses again.
- load 0x12A4 → err pulses once and cnt is unchanged. Same cycle with inc=1 → still no change.
- inc and dec both high for 5 cycles at cnt=0x0042 → cnt holds 0x0042 with no wrap. Then 58 inc → 0x0100.
- Assert reset for one cycle mid-scan (idx=2) with inc=1 → next cycle cnt=0, an=1111, seg=FF; the following cycle an=1110.

Source files
------------

// File: rtl/bcd_counter_sseg.sv
// bcd_counter_sseg: N-digit BCD up/down counter with load, wrap and load-error pulses, plus a
// time-multiplexed seven-segment scanner with optional leading-zero blanking.
//
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   load_i      load load_val_i into the counter (rejected if any nibble > 9)
//   load_val_i  BCD value to load, digit 0 at [3:0]
//   inc_i       decimal increment
//   dec_i       decimal decrement (inc_i & dec_i together hold)
//   cnt_o       current BCD count
//   wrap_o      one-cycle pulse on 9..9 -> 0..0 or 0..0 -> 9..9
//   err_o       one-cycle pulse when a load is rejected
//   an_o        active-low digit enables
//   seg_o       active-low segments {dp,g,f,e,d,c,b,a}; dp always off
module bcd_counter_sseg #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned DIV_BITS = 16,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  wrap_o,
    output logic                  err_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [7:0]            seg_o
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;

    // ------------------------------------------------------------------
    // Counter next state
    // ------------------------------------------------------------------
    logic       load_bad;
    logic       carry;
    logic [3:0] nib;

    always_comb begin
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        load_bad = 1'b0;
        carry    = 1'b0;
        nib      = 4'd0;

        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val_i[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end
        end

        if (load_i) begin
            // A rejected load still swallows inc/dec for this cycle.
            if (load_bad) begin
                err_d = 1'b1;
            end else begin
                cnt_d = load_val_i;
            end
        end else if (inc_i && dec_i) begin
            cnt_d = cnt_q;
        end else if (inc_i) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                nib = cnt_q[4*i +: 4];
                if (carry) begin
                    if (nib == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = nib + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
            // Carry out of the top digit means every digit was 9.
            wrap_d = carry;
        end else if (dec_i) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                nib = cnt_q[4*i +: 4];
                if (carry) begin
                    if (nib == 4'd0) begin
                        cnt_d[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_d[4*i +: 4] = nib - 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    // ------------------------------------------------------------------
    // Scanner next state
    // ------------------------------------------------------------------
    logic [DIGITS:0] zero_from;  // zero_from[i]: digits i..DIGITS-1 all zero
    logic [3:0]      cur_digit;
    logic            cur_blank;

    always_comb begin
        presc_d   = presc_q + 1'b1;
        idx_d     = idx_q;
        zero_from = '0;
        cur_digit = 4'd0;
        cur_blank = 1'b0;

        if (&presc_q) begin
            if (idx_q == IdxW'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        zero_from[DIGITS] = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (cnt_q[4*i +: 4] == 4'd0);
        end

        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit = cnt_q[4*i +: 4];
                // Digit 0 is never blanked so a zero count still shows "0".
                cur_blank = BLANK_LZ && (i > 0) && zero_from[i];
            end
        end

        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = {1'b1, cur_blank ? 7'b1111111 : encode(cur_digit)};
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;

endmodule

// File: tb/tb_bcd_counter_sseg.sv
// Directed testbench for bcd_counter_sseg with DIGITS=4, DIV_BITS=2, BLANK_LZ=1.
module tb_bcd_counter_sseg;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        load_i;
    logic [15:0] load_val_i;
    logic        inc_i;
    logic        dec_i;
    logic [15:0] cnt_o;
    logic        wrap_o;
    logic        err_o;
    logic [3:0]  an_o;
    logic [7:0]  seg_o;

    int checks   = 0;
    int failures = 0;
    int n        = 0;  // edges since reset release (edge 1 is first with reset low)

    always #5 clk = ~clk;

    bcd_counter_sseg #(
        .DIGITS   (4),
        .DIV_BITS (2),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .inc_i      (inc_i),
        .dec_i      (dec_i),
        .cnt_o      (cnt_o),
        .wrap_o     (wrap_o),
        .err_o      (err_o),
        .an_o       (an_o),
        .seg_o      (seg_o)
    );

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        logic r;
        r = reset_i;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n++;
    endtask

    function automatic logic [7:0] exp_seg(input logic [15:0] c, input int idx);
        logic [3:0]  d;
        logic [15:0] upper;
        d     = c[4*idx +: 4];
        upper = c >> (4 * idx);
        if (idx > 0 && upper == 16'h0000) return 8'hFF;
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hEE;
        endcase
    endfunction

    // Runs `cycles` edges with a steady count and checks the scan each cycle.
    task automatic test_scan(input logic [15:0] exp_cnt, input int cycles);
        int         idx;
        logic [3:0] ea;
        logic [7:0] es;
        for (int k = 0; k < cycles; k++) begin
            step();
            idx = ((n - 1) / 4) % 4;
            ea  = ~(4'b0001 << idx);
            es  = exp_seg(exp_cnt, idx);
            checks++;
            if (an_o !== ea) begin
                failures++;
                $display("FAIL scan_an n=%0d: got %b expected %b", n, an_o, ea);
            end
            checks++;
            if (seg_o !== es) begin
                failures++;
                $display("FAIL scan_seg n=%0d: got %h expected %h", n, seg_o, es);
            end
        end
    endtask

    task automatic test_reset();
        reset_i    = 1'b1;
        load_i     = 1'b0;
        load_val_i = 16'h0000;
        inc_i      = 1'b0;
        dec_i      = 1'b0;
        step();
        step();
        checks++;
        if (cnt_o !== 16'h0000) begin
            failures++; $display("FAIL reset_cnt: got %h expected 0000", cnt_o);
        end
        checks++;
        if (wrap_o !== 1'b0 || err_o !== 1'b0) begin
            failures++; $display("FAIL reset_pulses: got wrap=%b err=%b expected 0 0", wrap_o, err_o);
        end
        checks++;
        if (an_o !== 4'b1111) begin
            failures++; $display("FAIL reset_an: got %b expected 1111", an_o);
        end
        checks++;
        if (seg_o !== 8'hFF) begin
            failures++; $display("FAIL reset_seg: got %h expected ff", seg_o);
        end
        reset_i = 1'b0;
        test_scan(16'h0000, 20);
    endtask

    task automatic test_load_inc();
        load_i = 1'b1; load_val_i = 16'h0199;
        step();
        load_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0199) begin
            failures++; $display("FAIL load_0199: got %h expected 0199", cnt_o);
        end
        inc_i = 1'b1;
        step();
        inc_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0200 || wrap_o !== 1'b0) begin
            failures++; $display("FAIL inc_carry: got %h wrap=%b expected 0200 wrap=0", cnt_o, wrap_o);
        end
        step();
        test_scan(16'h0200, 16);
    endtask

    task automatic test_wrap();
        load_i = 1'b1; load_val_i = 16'h9999;
        step();
        load_i = 1'b0;
        inc_i  = 1'b1;
        step();
        inc_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0000 || wrap_o !== 1'b1) begin
            failures++; $display("FAIL inc_wrap: got %h wrap=%b expected 0000 wrap=1", cnt_o, wrap_o);
        end
        step();
        checks++;
        if (wrap_o !== 1'b0) begin
            failures++; $display("FAIL inc_wrap_len: got wrap=%b expected 0", wrap_o);
        end
        dec_i = 1'b1;
        step();
        dec_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h9999 || wrap_o !== 1'b1) begin
            failures++; $display("FAIL dec_wrap: got %h wrap=%b expected 9999 wrap=1", cnt_o, wrap_o);
        end
        step();
        checks++;
        if (wrap_o !== 1'b0 || cnt_o !== 16'h9999) begin
            failures++; $display("FAIL dec_wrap_len: got %h wrap=%b expected 9999 wrap=0", cnt_o, wrap_o);
        end
    endtask

    task automatic test_err();
        load_i = 1'b1; load_val_i = 16'h12A4;
        step();
        load_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || cnt_o !== 16'h9999) begin
            failures++; $display("FAIL load_err: got %h err=%b expected 9999 err=1", cnt_o, err_o);
        end
        step();
        checks++;
        if (err_o !== 1'b0) begin
            failures++; $display("FAIL load_err_len: got err=%b expected 0", err_o);
        end
        load_i = 1'b1; inc_i = 1'b1;
        step();
        load_i = 1'b0; inc_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || cnt_o !== 16'h9999 || wrap_o !== 1'b0) begin
            failures++;
            $display("FAIL load_err_inc: got %h err=%b wrap=%b expected 9999 err=1 wrap=0",
                     cnt_o, err_o, wrap_o);
        end
        step();
        checks++;
        if (err_o !== 1'b0 || cnt_o !== 16'h9999) begin
            failures++; $display("FAIL load_err_inc_after: got %h err=%b expected 9999 err=0", cnt_o, err_o);
        end
    endtask

    task automatic test_hold_then_inc();
        load_i = 1'b1; load_val_i = 16'h0042;
        step();
        load_i = 1'b0;
        inc_i  = 1'b1; dec_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (cnt_o !== 16'h0042 || wrap_o !== 1'b0) begin
                failures++; $display("FAIL both_hold k=%0d: got %h wrap=%b expected 0042 wrap=0", k, cnt_o, wrap_o);
            end
        end
        dec_i = 1'b0;
        for (int k = 0; k < 58; k++) begin
            step();
            if (wrap_o !== 1'b0) begin
                failures++; $display("FAIL inc_run_wrap k=%0d: got wrap=%b expected 0", k, wrap_o);
            end
        end
        checks++;
        inc_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0100) begin
            failures++; $display("FAIL inc_58: got %h expected 0100", cnt_o);
        end
        dec_i = 1'b1;
        step();
        dec_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0099 || wrap_o !== 1'b0) begin
            failures++; $display("FAIL dec_borrow: got %h wrap=%b expected 0099 wrap=0", cnt_o, wrap_o);
        end
        step();
        test_scan(16'h0099, 16);
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        // Advance until the scanner's current index is 2.
        while (((n / 4) % 4) != 2 && guard < 32) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 32) begin
            failures++; $display("FAIL reset_mid_sync: got guard=%0d expected <32", guard);
        end
        reset_i = 1'b1; inc_i = 1'b1;
        step();
        reset_i = 1'b0; inc_i = 1'b0;
        checks++;
        if (cnt_o !== 16'h0000 || an_o !== 4'b1111 || seg_o !== 8'hFF || wrap_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got cnt=%h an=%b seg=%h wrap=%b expected 0000 1111 ff 0",
                     cnt_o, an_o, seg_o, wrap_o);
        end
        step();
        checks++;
        if (an_o !== 4'b1110 || seg_o !== 8'hC0) begin
            failures++; $display("FAIL reset_mid_after: got an=%b seg=%h expected 1110 c0", an_o, seg_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_inc();
        test_wrap();
        test_err();
        test_hold_then_inc();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
